// File: rtl/wb_write_queue.sv
// Retire queue for the single GRF write port: merges W-stage and MD results,
// buffers them in arrival order, retires one per cycle, and serves forwarding lookups.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p_valid,
    output logic        p_ready,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_data,
    input  logic [31:0] p_pc,

    input  logic        m_valid,
    output logic        m_ready,
    input  logic [4:0]  m_addr,
    input  logic [31:0] m_data,
    input  logic [31:0] m_pc,

    output logic        RegWrite,
    output logic [4:0]  RF_WA,
    output logic [31:0] RF_WD,
    output logic [31:0] Pc,

    input  logic [4:0]  q_addr,
    output logic        q_hit,
    output logic [31:0] q_data
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);

    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;

    logic [4:0]  addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [31:0] pc_q   [DEPTH];

    logic [AW:0]   free;
    logic          p_push, m_push, pop;
    logic [AW-1:0] m_slot;
    logic [AW-1:0] lk_idx;

    // Credit is taken from the registered count only, so ready never
    // depends on this cycle's pop and there is no comb loop.
    assign free    = CNT_FULL - count_q;
    assign p_ready = (free != '0);
    assign m_ready = p_valid ? (free >= CNT_TWO) : (free != '0);

    assign p_push = p_valid & p_ready & (p_addr != 5'd0);
    assign m_push = m_valid & m_ready & (m_addr != 5'd0);
    assign pop    = (count_q != '0);
    assign m_slot = wptr_q + {{(AW-1){1'b0}}, p_push};

    always_comb begin
        wptr_d  = wptr_q + {{(AW-1){1'b0}}, p_push}
                         + {{(AW-1){1'b0}}, m_push};
        rptr_d  = rptr_q + {{(AW-1){1'b0}}, pop};
        count_d = count_q + {{AW{1'b0}}, p_push}
                          + {{AW{1'b0}}, m_push}
                          - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (p_push) begin
                addr_q[wptr_q] <= p_addr;
                data_q[wptr_q] <= p_data;
                pc_q[wptr_q]   <= p_pc;
            end
            if (m_push) begin
                addr_q[m_slot] <= m_addr;
                data_q[m_slot] <= m_data;
                pc_q[m_slot]   <= m_pc;
            end
        end
    end

    assign RegWrite = pop;
    assign RF_WA    = pop ? addr_q[rptr_q] : 5'd0;
    assign RF_WD    = pop ? data_q[rptr_q] : 32'd0;
    assign Pc       = pop ? pc_q[rptr_q]   : 32'd0;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        q_hit  = 1'b0;
        q_data = 32'd0;
        lk_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = rptr_q + AW'(i);
            if (((AW+1)'(i) < count_q) && (q_addr != 5'd0) &&
                (addr_q[lk_idx] == q_addr)) begin
                q_hit  = 1'b1;
                q_data = data_q[lk_idx];
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed vector table, a back-pressure
// sequence, and random traffic against a queue-based reference model.
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_valid, m_valid;
    logic        p_ready, m_ready;
    logic [4:0]  p_addr, m_addr;
    logic [31:0] p_data, m_data, p_pc, m_pc;
    logic        RegWrite;
    logic [4:0]  RF_WA;
    logic [31:0] RF_WD, Pc;
    logic [4:0]  q_addr;
    logic        q_hit;
    logic [31:0] q_data;

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_ready(p_ready), .p_addr(p_addr),
        .p_data(p_data), .p_pc(p_pc),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .m_data(m_data), .m_pc(m_pc),
        .RegWrite(RegWrite), .RF_WA(RF_WA), .RF_WD(RF_WD), .Pc(Pc),
        .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: an ordered list of stored results.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    ent_t mq[$];
    bit   mvalid = 0;
    logic m_pr, m_mr;

    // Called after inputs settle, before the next rising edge.
    task automatic model_step(input string tag);
        int          free;
        logic        erw, ehit;
        logic [4:0]  ewa;
        logic [31:0] ewd, epc, eqd;
        ent_t        e;
        #1;
        free = DEPTH - mq.size();
        m_pr = (free >= 1);
        m_mr = p_valid ? (free >= 2) : (free >= 1);
        erw  = (mq.size() != 0);
        ewa  = erw ? mq[0].a : 5'd0;
        ewd  = erw ? mq[0].d : 32'd0;
        epc  = erw ? mq[0].p : 32'd0;
        ehit = 1'b0;
        eqd  = 32'd0;
        foreach (mq[i])
            if (q_addr != 0 && mq[i].a == q_addr) begin
                ehit = 1'b1;
                eqd  = mq[i].d;
            end
        if (mvalid) begin
            chk({tag, ".p_ready"}, 32'(p_ready), 32'(m_pr));
            chk({tag, ".m_ready"}, 32'(m_ready), 32'(m_mr));
            chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(erw));
            chk({tag, ".RF_WA"}, 32'(RF_WA), 32'(ewa));
            chk({tag, ".RF_WD"}, RF_WD, ewd);
            chk({tag, ".Pc"}, Pc, epc);
            chk({tag, ".q_hit"}, 32'(q_hit), 32'(ehit));
            chk({tag, ".q_data"}, q_data, eqd);
        end
        if (!reset) begin
            mq.delete();
            mvalid = 1;
        end else if (mvalid) begin
            if (mq.size() != 0) void'(mq.pop_front());
            if (p_valid && m_pr && p_addr != 0) begin
                e.a = p_addr; e.d = p_data; e.p = p_pc;
                mq.push_back(e);
            end
            if (m_valid && m_mr && m_addr != 0) begin
                e.a = m_addr; e.d = m_data; e.p = m_pc;
                mq.push_back(e);
            end
        end
    endtask

    typedef struct {
        logic        rst, pv, mv, chk;
        logic [4:0]  pa, ma, qa;
        logic [31:0] pd, pp, md, mp;
        logic        pr, mr, rw, hit;
        logic [4:0]  wa;
        logic [31:0] wd, pc, qd;
    } vec_t;

    function automatic vec_t iv(
        input logic rst, input logic pv, input logic [4:0] pa,
        input logic [31:0] pd, input logic [31:0] pp,
        input logic mv, input logic [4:0] ma,
        input logic [31:0] md, input logic [31:0] mp,
        input logic [4:0] qa);
        vec_t v;
        v = '{default: '0};
        v.rst = rst; v.pv = pv; v.pa = pa; v.pd = pd; v.pp = pp;
        v.mv = mv; v.ma = ma; v.md = md; v.mp = mp; v.qa = qa;
        return v;
    endfunction

    function automatic vec_t ex(
        input vec_t v, input logic pr, input logic mr, input logic rw,
        input logic [4:0] wa, input logic [31:0] wd,
        input logic [31:0] pc, input logic hit, input logic [31:0] qd);
        vec_t r;
        r = v;
        r.chk = 1; r.pr = pr; r.mr = mr; r.rw = rw; r.wa = wa;
        r.wd = wd; r.pc = pc; r.hit = hit; r.qd = qd;
        return r;
    endfunction

    vec_t vt[17];
    logic [4:0] exp_ord [8] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd6, 5'd8};
    logic [4:0] p_src [4]   = '{5'd1, 5'd3, 5'd5, 5'd7};
    logic [4:0] m_src [4]   = '{5'd2, 5'd4, 5'd6, 5'd8};

    initial begin
        vec_t v;
        logic [4:0] got[$];
        int pi, mi;

        vt[0]  = iv(0, 1, 3, 1, 0, 0, 0, 0, 0, 3);
        vt[1]  = ex(iv(0, 1, 3, 1, 0, 0, 0, 0, 0, 3), 1, 1, 0, 0, 0, 0, 0, 0);
        vt[2]  = ex(iv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0, 0, 0);
        vt[3]  = ex(iv(1, 1, 5, 'h1234, 'h3000, 0, 0, 0, 0, 5),
                    1, 1, 0, 0, 0, 0, 0, 0);
        vt[4]  = ex(iv(1, 0, 0, 0, 0, 0, 0, 0, 0, 5),
                    1, 1, 1, 5, 'h1234, 'h3000, 1, 'h1234);
        vt[5]  = ex(iv(1, 0, 0, 0, 0, 0, 0, 0, 0, 5), 1, 1, 0, 0, 0, 0, 0, 0);
        vt[6]  = ex(iv(1, 1, 7, 'hA, 'h100, 1, 7, 'hB, 'h104, 7),
                    1, 1, 0, 0, 0, 0, 0, 0);
        vt[7]  = ex(iv(1, 0, 0, 0, 0, 0, 0, 0, 0, 7),
                    1, 1, 1, 7, 'hA, 'h100, 1, 'hB);
        vt[8]  = ex(iv(1, 0, 0, 0, 0, 0, 0, 0, 0, 7),
                    1, 1, 1, 7, 'hB, 'h104, 1, 'hB);
        vt[9]  = ex(iv(1, 0, 0, 0, 0, 0, 0, 0, 0, 7), 1, 1, 0, 0, 0, 0, 0, 0);
        vt[10] = ex(iv(1, 1, 0, 'hFFFF, 'h200, 0, 0, 0, 0, 0),
                    1, 1, 0, 0, 0, 0, 0, 0);
        vt[11] = ex(iv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0, 0, 0);
        vt[12] = ex(iv(1, 1, 1, 'h11, 'h10, 1, 2, 'h22, 'h14, 2),
                    1, 1, 0, 0, 0, 0, 0, 0);
        vt[13] = ex(iv(1, 1, 3, 'h33, 'h18, 1, 4, 'h44, 'h1C, 2),
                    1, 1, 1, 1, 'h11, 'h10, 1, 'h22);
        vt[14] = ex(iv(0, 1, 9, 'h99, 'h20, 0, 0, 0, 0, 4),
                    1, 0, 1, 2, 'h22, 'h14, 1, 'h44);
        vt[15] = ex(iv(1, 0, 0, 0, 0, 0, 0, 0, 0, 4), 1, 1, 0, 0, 0, 0, 0, 0);
        vt[16] = ex(iv(1, 0, 0, 0, 0, 0, 0, 0, 0, 3), 1, 1, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 17; k++) begin
            v = vt[k];
            @(negedge clk);
            reset = v.rst; q_addr = v.qa;
            p_valid = v.pv; p_addr = v.pa; p_data = v.pd; p_pc = v.pp;
            m_valid = v.mv; m_addr = v.ma; m_data = v.md; m_pc = v.mp;
            model_step($sformatf("vec%0d.model", k));
            if (v.chk) begin
                chk($sformatf("vec%0d.p_ready", k), 32'(p_ready), 32'(v.pr));
                chk($sformatf("vec%0d.m_ready", k), 32'(m_ready), 32'(v.mr));
                chk($sformatf("vec%0d.RegWrite", k), 32'(RegWrite), 32'(v.rw));
                chk($sformatf("vec%0d.RF_WA", k), 32'(RF_WA), 32'(v.wa));
                chk($sformatf("vec%0d.RF_WD", k), RF_WD, v.wd);
                chk($sformatf("vec%0d.Pc", k), Pc, v.pc);
                chk($sformatf("vec%0d.q_hit", k), 32'(q_hit), 32'(v.hit));
                chk($sformatf("vec%0d.q_data", k), q_data, v.qd);
            end
        end

        // Both producers stream; MD must yield to the pipe under pressure.
        pi = 0;
        mi = 0;
        for (int c = 0; c < 30 && got.size() < 8; c++) begin
            @(negedge clk);
            reset = 1; q_addr = 5'd0;
            p_valid = (pi < 4);
            p_addr  = (pi < 4) ? p_src[pi] : 5'd0;
            p_data  = 32'(p_addr) << 8;
            p_pc    = 32'h1000 + (32'(p_addr) << 2);
            m_valid = (mi < 4);
            m_addr  = (mi < 4) ? m_src[mi] : 5'd0;
            m_data  = 32'(m_addr) << 8;
            m_pc    = 32'h1000 + (32'(m_addr) << 2);
            model_step("stream");
            if (c == 2) begin
                chk("stream.sat_p_ready", 32'(p_ready), 32'd1);
                chk("stream.sat_m_ready", 32'(m_ready), 32'd0);
            end
            if (RegWrite === 1'b1) got.push_back(RF_WA);
            if (p_valid && m_pr) pi++;
            if (m_valid && m_mr) mi++;
        end
        chk("stream.retire_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < got.size())
                chk($sformatf("stream.order%0d", i), 32'(got[i]), 32'(exp_ord[i]));

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            reset   = ($urandom_range(0, 39) != 0);
            p_valid = $urandom_range(0, 1) == 1;
            p_addr  = 5'($urandom_range(0, 7));
            p_data  = $urandom;
            p_pc    = $urandom;
            m_valid = $urandom_range(0, 1) == 1;
            m_addr  = 5'($urandom_range(0, 7));
            m_data  = $urandom;
            m_pc    = $urandom;
            q_addr  = 5'($urandom_range(0, 7));
            model_step($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
